// File: rtl/datapath_pkg.sv
// Shared datapath definitions for the ALU operand stage: default operand and
// immediate widths plus the immediate-mode and forwarding-select encodings.
package datapath_pkg;

   localparam int DEFAULT_DATA_WIDTH = 32;
   localparam int DEFAULT_IMM_WIDTH  = 16;

   // Immediate extension modes; the reserved code behaves like sign-extend.
   typedef enum logic [1:0] {
      IMM_SIGN  = 2'b00,
      IMM_ZERO  = 2'b01,
      IMM_UPPER = 2'b10,
      IMM_RSVD  = 2'b11
   } imm_mode_e;

   // Operand forwarding sources; the reserved code behaves like register.
   typedef enum logic [1:0] {
      FWD_REG   = 2'b00,
      FWD_EXMEM = 2'b01,
      FWD_MEMWB = 2'b10,
      FWD_RSVD  = 2'b11
   } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Handshake and data bundle of the ALU operand stage. The master side is the
// surrounding pipeline (upstream producer plus downstream consumer); the slave
// side is the operand stage itself.
interface alu_operand_stage_if
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH
);

   logic                  in_valid;
   logic                  in_ready;
   logic [DATA_WIDTH-1:0] in_reg_a;
   logic [DATA_WIDTH-1:0] in_reg_b;
   logic [IMM_WIDTH-1:0]  in_immediate;
   imm_mode_e             imm_mode;
   logic                  select_b;
   fwd_sel_e              fwd_sel_a;
   fwd_sel_e              fwd_sel_b;
   logic [DATA_WIDTH-1:0] exmem_data;
   logic [DATA_WIDTH-1:0] memwb_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_a;
   logic [DATA_WIDTH-1:0] out_b;

   modport master (
      output in_valid, in_reg_a, in_reg_b, in_immediate, imm_mode, select_b,
             fwd_sel_a, fwd_sel_b, exmem_data, memwb_data, out_ready,
      input  in_ready, out_valid, out_a, out_b
   );

   modport slave (
      input  in_valid, in_reg_a, in_reg_b, in_immediate, imm_mode, select_b,
             fwd_sel_a, fwd_sel_b, exmem_data, memwb_data, out_ready,
      output in_ready, out_valid, out_a, out_b
   );

endinterface

// File: rtl/imm_extend.sv
// Combinational immediate extender: sign-extend, zero-extend, or place the
// immediate in the upper bits of the operand with the low bits cleared.
module imm_extend
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH
) (
   input  imm_mode_e             imm_mode,
   input  logic [IMM_WIDTH-1:0]  imm,
   output logic [DATA_WIDTH-1:0] ext
);

   localparam int PAD = DATA_WIDTH - IMM_WIDTH;

   // Pick the extension form; sign-extend doubles as the reserved-mode result.
   always_comb begin
      ext = {{PAD{imm[IMM_WIDTH-1]}}, imm};
      case (imm_mode)
         IMM_ZERO:  ext = {{PAD{1'b0}}, imm};
         IMM_UPPER: ext = {imm, {PAD{1'b0}}};
         default:   ;
      endcase
   end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand stage: selects forwarded/register/immediate operands and
// registers them behind a valid/ready handshake with one cycle of latency.
// Optional feature macro: OPERAND_SKID_EN adds a one-entry skid buffer so
// in_ready comes from a register instead of depending on out_ready.
module alu_operand_stage
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int IMM_WIDTH  = DEFAULT_IMM_WIDTH
) (
   input logic                clk,
   input logic                reset,
   input logic                flush,
   alu_operand_stage_if.slave bus
);

   logic [DATA_WIDTH-1:0] ext_imm;
   logic [DATA_WIDTH-1:0] op_a;
   logic [DATA_WIDTH-1:0] op_b;
   logic                  accept;
   logic                  out_valid_q;
   logic [DATA_WIDTH-1:0] out_a_q;
   logic [DATA_WIDTH-1:0] out_b_q;

   function automatic logic [DATA_WIDTH-1:0] forward(
      input fwd_sel_e              sel,
      input logic [DATA_WIDTH-1:0] reg_data,
      input logic [DATA_WIDTH-1:0] exmem,
      input logic [DATA_WIDTH-1:0] memwb
   );
      case (sel)
         FWD_EXMEM: return exmem;
         FWD_MEMWB: return memwb;
         default:   return reg_data;
      endcase
   endfunction

   imm_extend #(
      .DATA_WIDTH (DATA_WIDTH),
      .IMM_WIDTH  (IMM_WIDTH)
   ) u_imm_extend (
      .imm_mode (bus.imm_mode),
      .imm      (bus.in_immediate),
      .ext      (ext_imm)
   );

   // Operand selection; an immediate on B wins over any B forwarding choice.
   always_comb begin
      op_a = forward(bus.fwd_sel_a, bus.in_reg_a, bus.exmem_data, bus.memwb_data);
      op_b = forward(bus.fwd_sel_b, bus.in_reg_b, bus.exmem_data, bus.memwb_data);
      if (bus.select_b) begin
         op_b = ext_imm;
      end
   end

   assign accept        = bus.in_valid && bus.in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_a     = out_a_q;
   assign bus.out_b     = out_b_q;

`ifdef OPERAND_SKID_EN
   logic                  skid_full;
   logic [DATA_WIDTH-1:0] skid_a;
   logic [DATA_WIDTH-1:0] skid_b;

   assign bus.in_ready = !reset && !skid_full;

   // Output register backed by one skid entry: a set accepted while stalled
   // parks in the skid and moves to the output on the next consume.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
         skid_full   <= 1'b0;
         skid_a      <= '0;
         skid_b      <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         skid_full   <= 1'b0;
      end else if (!out_valid_q || bus.out_ready) begin
         if (skid_full) begin
            out_a_q     <= skid_a;
            out_b_q     <= skid_b;
            out_valid_q <= 1'b1;
            skid_full   <= 1'b0;
         end else if (accept) begin
            out_a_q     <= op_a;
            out_b_q     <= op_b;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_a    <= op_a;
         skid_b    <= op_b;
         skid_full <= 1'b1;
      end
   end
`else
   assign bus.in_ready = !reset && (!out_valid_q || bus.out_ready);

   // Single output register; data only moves on an accept, valid drops when
   // the held set is consumed with nothing new arriving.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_a_q     <= '0;
         out_b_q     <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
      end else if (accept) begin
         out_a_q     <= op_a;
         out_b_q     <= op_b;
         out_valid_q <= 1'b1;
      end else if (bus.out_ready) begin
         out_valid_q <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage. A queue-based reference model
// (capacity 1, or 2 when OPERAND_SKID_EN is defined) predicts handshake and
// operand values; directed steps cover the named scenarios, then a random soak.
module tb_alu_operand_stage;
   import datapath_pkg::*;

   localparam int DW = 32;
   localparam int IW = 16;

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } set_t;

   logic clk = 1'b0;
   logic reset;
   logic flush;

   alu_operand_stage_if #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) bus ();

   alu_operand_stage #(
      .DATA_WIDTH (DW),
      .IMM_WIDTH  (IW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   set_t          q[$];
   logic [DW-1:0] shown_a;
   logic [DW-1:0] shown_b;
   int            compared   = 0;
   int            mismatched = 0;
   int            dut_accepts = 0;

   function automatic logic [DW-1:0] ref_ext(input logic [1:0] mode, input logic [IW-1:0] imm);
      logic signed [DW-1:0] s;
      s = $signed(imm);
      case (mode)
         2'd1:    return {{(DW-IW){1'b0}}, imm};
         2'd2:    return {{(DW-IW){1'b0}}, imm} << (DW - IW);
         default: return s;
      endcase
   endfunction

   function automatic logic [DW-1:0] ref_fwd(input logic [1:0] sel, input logic [DW-1:0] r);
      case (sel)
         2'd1:    return bus.exmem_data;
         2'd2:    return bus.memwb_data;
         default: return r;
      endcase
   endfunction

   function automatic logic exp_in_ready();
      if (reset) return 1'b0;
`ifdef OPERAND_SKID_EN
      return q.size() < 2;
`else
      return (q.size() == 0) || bus.out_ready;
`endif
   endfunction

   task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic ready);
      bus.in_valid     = valid;
      bus.out_ready    = ready;
      bus.in_reg_a     = $urandom();
      bus.in_reg_b     = $urandom();
      bus.in_immediate = IW'($urandom());
      bus.imm_mode     = imm_mode_e'(2'($urandom_range(0, 3)));
      bus.select_b     = 1'($urandom_range(0, 1));
      bus.fwd_sel_a    = fwd_sel_e'(2'($urandom_range(0, 3)));
      bus.fwd_sel_b    = fwd_sel_e'(2'($urandom_range(0, 3)));
      bus.exmem_data   = $urandom();
      bus.memwb_data   = $urandom();
   endtask

   // One clock: check in_ready before the edge, advance the model, check outputs after.
   task automatic tick();
      logic ir;
      logic acc;
      logic cons;
      set_t nxt;
      #1;
      ir = exp_in_ready();
      checkOutput("in_ready", DW'(bus.in_ready), DW'(ir));
      if (bus.in_valid && bus.in_ready) dut_accepts++;
      acc   = bus.in_valid && ir;
      cons  = (q.size() > 0) && bus.out_ready;
      nxt.a = ref_fwd(bus.fwd_sel_a, bus.in_reg_a);
      nxt.b = bus.select_b ? ref_ext(bus.imm_mode, bus.in_immediate)
                           : ref_fwd(bus.fwd_sel_b, bus.in_reg_b);
      @(posedge clk);
      #1;
      if (reset) begin
         q.delete();
         shown_a = '0;
         shown_b = '0;
      end else if (flush) begin
         q.delete();
      end else begin
         if (cons) void'(q.pop_front());
         if (acc) q.push_back(nxt);
      end
      if (q.size() > 0) begin
         shown_a = q[0].a;
         shown_b = q[0].b;
      end
      checkOutput("out_valid", DW'(bus.out_valid), DW'(q.size() > 0));
      checkOutput("out_a", bus.out_a, shown_a);
      checkOutput("out_b", bus.out_b, shown_b);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [DW-1:0] upper_exp[4];
      int            acc_before;
      upper_exp = '{32'hFFFF8001, 32'h00008001, 32'h80010000, 32'hFFFF8001};

      // Reset state
      reset = 1'b1;
      flush = 1'b0;
      applyStimulus(1'b1, 1'b0);
      tick();
      tick();
      reset = 1'b0;

      // Immediate modes on 0x8001
      for (int m = 0; m < 4; m++) begin
         applyStimulus(1'b1, 1'b1);
         bus.select_b     = 1'b1;
         bus.in_immediate = 16'h8001;
         bus.imm_mode     = imm_mode_e'(2'(m));
         tick();
         checkOutput($sformatf("imm8001_mode%0d", m), bus.out_b, upper_exp[m]);
      end

      // Zero immediate is mode-independent
      for (int m = 0; m < 4; m++) begin
         applyStimulus(1'b1, 1'b1);
         bus.select_b     = 1'b1;
         bus.in_immediate = '0;
         bus.imm_mode     = imm_mode_e'(2'(m));
         tick();
         checkOutput($sformatf("imm0_mode%0d", m), bus.out_b, '0);
      end

      // Forwarding from both later stages
      applyStimulus(1'b1, 1'b1);
      bus.fwd_sel_a  = FWD_EXMEM;
      bus.exmem_data = 32'hDEADBEEF;
      bus.fwd_sel_b  = FWD_MEMWB;
      bus.memwb_data = 32'h12345678;
      bus.select_b   = 1'b0;
      tick();
      checkOutput("fwd_out_a", bus.out_a, 32'hDEADBEEF);
      checkOutput("fwd_out_b", bus.out_b, 32'h12345678);
      applyStimulus(1'b0, 1'b1);
      tick();

      // Stall for three cycles with input offered
      applyStimulus(1'b1, 1'b0);
      tick();
      acc_before = dut_accepts;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 1'b0);
         tick();
      end
`ifdef OPERAND_SKID_EN
      checkOutput("stall_extra_accepts", DW'(dut_accepts - acc_before), DW'(1));
`else
      checkOutput("stall_extra_accepts", DW'(dut_accepts - acc_before), DW'(0));
`endif
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 1'b1);
         tick();
      end

      // Flush wins over a simultaneous offer
      applyStimulus(1'b1, 1'b0);
      tick();
      applyStimulus(1'b1, 1'b0);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checkOutput("flush_out_valid", DW'(bus.out_valid), DW'(0));
      applyStimulus(1'b0, 1'b1);
      tick();

      // Reset during a stall
      applyStimulus(1'b1, 1'b0);
      bus.fwd_sel_a = FWD_REG;
      bus.in_reg_a  = 32'h55;
      tick();
      checkOutput("pre_reset_out_a", bus.out_a, 32'h55);
      applyStimulus(1'b0, 1'b0);
      tick();
      reset = 1'b1;
      applyStimulus(1'b1, 1'b0);
      tick();
      reset = 1'b0;
      checkOutput("reset_out_valid", DW'(bus.out_valid), DW'(0));
      checkOutput("reset_out_a", bus.out_a, '0);

      // Eight back-to-back transfers
      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b1);
         tick();
         checkOutput($sformatf("b2b_valid%0d", i), DW'(bus.out_valid), DW'(1));
      end
      applyStimulus(1'b0, 1'b1);
      tick();

      // Random soak including flushes and reserved encodings
      for (int i = 0; i < 300; i++) begin
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         flush = ($urandom_range(0, 15) == 0);
         tick();
      end
      flush = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: operand width in bits, minimum IMM_WIDTH*2.
REQ-002 SHALL have parameter IMM_WIDTH, default 16: immediate field width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port flush, input, 1 bit: discards held operands.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream offers an operand set.
REQ-007 SHALL have port in_ready, output, 1 bit: stage accepts an operand set this cycle.
REQ-008 SHALL have ports in_reg_a and in_reg_b, input, DATA_WIDTH bits each: register-file read data.
REQ-009 SHALL have port in_immediate, input, IMM_WIDTH bits: raw immediate field.
REQ-010 SHALL have port imm_mode, input, 2 bits: 00 sign-extend, 01 zero-extend, 10 upper (imm placed in the top IMM_WIDTH bits, low bits zero), 11 treated as 00.
REQ-011 SHALL have port select_b, input, 1 bit: 1 selects the extended immediate for operand B.
REQ-012 SHALL have ports fwd_sel_a and fwd_sel_b, input, 2 bits each: 00 register, 01 exmem_data, 10 memwb_data, 11 treated as 00.
REQ-013 SHALL have ports exmem_data and memwb_data, input, DATA_WIDTH bits each: forwarding sources.
REQ-014 SHALL have port out_valid, output, 1 bit: out_a and out_b hold a valid operand set.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream consumes the operand set this cycle.
REQ-016 SHALL have ports out_a and out_b, output, DATA_WIDTH bits each: registered ALU operands.

Function
REQ-017 SHALL compute A = forward(fwd_sel_a, in_reg_a) combinationally from the inputs.
REQ-018 SHALL compute B = select_b ? ext(imm_mode, in_immediate) : forward(fwd_sel_b, in_reg_b); select_b takes priority over fwd_sel_b.
REQ-019 SHALL perform a transfer when in_valid && in_ready is high at a clock edge; the computed A/B then appear on out_a/out_b one cycle later with out_valid=1, a latency of 1.
REQ-020 SHALL hold out_a, out_b and out_valid stable while out_valid && !out_ready; no input is accepted that would overwrite them.
REQ-021 SHALL, in the baseline build, drive in_ready = !out_valid || out_ready, so a simultaneous consume and accept sustains one transfer per cycle.
REQ-022 SHALL, when flush=1 at a clock edge, clear every valid bit and ignore any in_valid presented in that cycle; flush overrides a simultaneous accept.
REQ-023 SHALL leave out_a and out_b unchanged when a cycle produces no transfer; data registers change only on an accept.
REQ-024 SHALL produce the same result for every imm_mode when IMM_WIDTH=DATA_WIDTH/2 and imm=0.

Reset
REQ-025 SHALL, when reset=1 at a clock edge, clear out_valid, all internal valid bits, out_a and out_b to 0.
REQ-026 SHALL give reset priority over flush and over any accept.
REQ-027 SHALL drive in_ready low during the reset cycle and from the first cycle after reset follow REQ-021 (or REQ-029 when OPERAND_SKID_EN is defined).

Configuration
REQ-028 SHALL use macro OPERAND_SKID_EN to include or exclude a one-entry skid buffer.
REQ-029 SHALL, with OPERAND_SKID_EN defined, register in_ready as !skid_full, with no combinational path from out_ready.
  - The skid entry captures a set accepted while the output is stalled.
  - The skid entry moves to the output on the next consume.
  - Order is strictly FIFO.
  - Throughput stays at one transfer per cycle.
REQ-030 SHALL, without OPERAND_SKID_EN, contain no skid storage and behave exactly as REQ-021.

Structure
REQ-031 SHALL take the imm_mode and fwd_sel encodings as enumerated typedefs from the shared package datapath_pkg; the package also holds the default width constants.
REQ-032 SHALL implement immediate extension in the sub-module imm_extend (combinational, parameterised by DATA_WIDTH and IMM_WIDTH).

Verification
REQ-033 SHALL pass this scenario: imm=0x8001, select_b=1, each imm_mode in turn -> out_b = 0xFFFF8001, 0x00008001, 0x80010000, 0xFFFF8001.
REQ-034 SHALL pass this scenario: fwd_sel_a=01, exmem_data=0xDEADBEEF, fwd_sel_b=10, memwb_data=0x12345678, select_b=0 -> out_a=0xDEADBEEF, out_b=0x12345678, one cycle after the accept.
REQ-035 SHALL pass this scenario: out_ready=0 for 3 cycles with in_valid held high -> output held; baseline in_ready=0; skid build accepts exactly one extra set, then drains both in order.
REQ-036 SHALL pass this scenario: flush and in_valid high together while out_valid=1 -> out_valid=0 on the next cycle and no transfer recorded.
REQ-037 SHALL pass this scenario: reset asserted mid-stall with out_valid=1 and out_a=0x55 -> out_valid=0 and out_a=0 after one edge.
REQ-038 SHALL pass this scenario: back-to-back 8 transfers with out_ready=1 -> 8 outputs on consecutive cycles, matching the scoreboard.
